// File: rtl/sync_fifo_pkg.sv
// Shared defaults and types for the single-clock FIFO.
// Imported by the top and the RAM.
package sync_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 10;

  typedef enum logic [1:0] {
    FILL_HOLD,
    FILL_INC,
    FILL_DEC
  } fill_op_e;

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port RAM for the FIFO.
// Port A writes synchronously; port B has a registered read.
module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] rdata_d;

  // Output register only moves on a read, so it holds otherwise.
  always_comb begin
    rdata_d = rdata_q;
    if (i_re) rdata_d = mem[i_raddr];
  end

  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
    rdata_q <= rdata_d;
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, fill count and flags.
// Storage lives in sync_fifo_ram.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_rd,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [ADDR_WIDTH:0]   o_fill
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FILL_MAX = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] FILL_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   fill_q, fill_d;
  logic                  empty_q, empty_d;
  logic                  full_q, full_d;
  logic                  valid_q, valid_d;
  logic                  wr_en, rd_en;
  logic [DATA_WIDTH-1:0] ram_q;
  fill_op_e              op;

  // A write at full is accepted only when a read frees a slot that edge.
  always_comb begin
    wr_en   = i_wr & (~full_q | i_rd);
    rd_en   = i_rd & ~empty_q;
    op      = FILL_HOLD;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    fill_d  = fill_q;
    valid_d = valid_q | rd_en;
    unique case ({wr_en, rd_en})
      2'b10:   op = FILL_INC;
      2'b01:   op = FILL_DEC;
      default: op = FILL_HOLD;
    endcase
    if (wr_en) wptr_d = wptr_q + PTR_ONE;
    if (rd_en) rptr_d = rptr_q + PTR_ONE;
    unique case (op)
      FILL_INC: fill_d = fill_q + FILL_ONE;
      FILL_DEC: fill_d = fill_q - FILL_ONE;
      default:  fill_d = fill_q;
    endcase
    empty_d = (fill_d == '0);
    full_d  = (fill_d == FILL_MAX);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      fill_q  <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      fill_q  <= fill_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      valid_q <= valid_d;
    end
  end

  sync_fifo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .i_clk  (i_clk),
    .i_we   (wr_en),
    .i_waddr(wptr_q),
    .i_wdata(i_data),
    .i_re   (rd_en),
    .i_raddr(rptr_q),
    .o_rdata(ram_q)
  );

  // RAM has no reset; mask its register until a read since reset.
  assign o_data  = valid_q ? ram_q : '0;
  assign o_full  = full_q;
  assign o_empty = empty_q;
  assign o_fill  = fill_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo against a queue model.
module tb_sync_fifo;

  localparam int DEPTH = 1024;

  logic        i_clk;
  logic        i_rst;
  logic        i_wr;
  logic [31:0] i_data;
  logic        i_rd;
  logic [31:0] o_data;
  logic        o_full;
  logic        o_empty;
  logic [10:0] o_fill;

  sync_fifo dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_wr   (i_wr),
    .i_data (i_data),
    .i_rd   (i_rd),
    .o_data (o_data),
    .o_full (o_full),
    .o_empty(o_empty),
    .o_fill (o_fill)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] q[$];
  logic [31:0] m_data = '0;

  typedef struct {
    logic        wr;
    logic [31:0] d;
    logic        rd;
    logic [31:0] e_data;
    int          e_fill;
    logic        e_empty;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_model();
    chk("data", o_data, m_data);
    chk("fill", 32'(o_fill), 32'(q.size()));
    chk("empty", 32'(o_empty), 32'(q.size() == 0));
    chk("full", 32'(o_full), 32'(q.size() == DEPTH));
    chk("flags_excl", 32'(o_full & o_empty), 32'd0);
  endtask

  task automatic step(input logic wr, input logic [31:0] d,
                      input logic rd, input bit check);
    bit m_wr, m_rd;
    i_wr   = wr;
    i_data = d;
    i_rd   = rd;
    @(posedge i_clk);
    m_wr = wr && (q.size() < DEPTH || rd);
    m_rd = rd && (q.size() > 0);
    if (m_rd) m_data = q.pop_front();
    if (m_wr) q.push_back(d);
    #1;
    if (check) check_model();
  endtask

  initial begin
    i_rst  = 1'b1;
    i_wr   = 1'b0;
    i_rd   = 1'b0;
    i_data = '0;
    #1;
    chk("rst0_empty", 32'(o_empty), 32'd1);
    chk("rst0_full", 32'(o_full), 32'd0);
    chk("rst0_fill", 32'(o_fill), 32'd0);
    chk("rst0_data", o_data, 32'd0);
    #6 i_rst = 1'b0;
    @(posedge i_clk);
    #1;

    vecs[0] = '{1'b1, 32'h11, 1'b0, 32'h00, 1, 1'b0};
    vecs[1] = '{1'b1, 32'h22, 1'b0, 32'h00, 2, 1'b0};
    vecs[2] = '{1'b1, 32'h33, 1'b0, 32'h00, 3, 1'b0};
    vecs[3] = '{1'b0, 32'h00, 1'b1, 32'h11, 2, 1'b0};
    vecs[4] = '{1'b0, 32'h00, 1'b1, 32'h22, 1, 1'b0};
    vecs[5] = '{1'b0, 32'h00, 1'b1, 32'h33, 0, 1'b1};
    vecs[6] = '{1'b0, 32'h00, 1'b1, 32'h33, 0, 1'b1};
    vecs[7] = '{1'b1, 32'h5A, 1'b1, 32'h33, 1, 1'b0};
    vecs[8] = '{1'b0, 32'h00, 1'b1, 32'h5A, 0, 1'b1};
    vecs[9] = '{1'b0, 32'h00, 1'b0, 32'h5A, 0, 1'b1};
    foreach (vecs[i]) begin
      step(vecs[i].wr, vecs[i].d, vecs[i].rd, 1'b0);
      chk($sformatf("vec%0d_data", i), o_data, vecs[i].e_data);
      chk($sformatf("vec%0d_fill", i), 32'(o_fill), 32'(vecs[i].e_fill));
      chk($sformatf("vec%0d_empty", i), 32'(o_empty), 32'(vecs[i].e_empty));
    end

    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h1000 + i, 1'b0, 1'b1);
    chk("full_at_depth", 32'(o_full), 32'd1);
    chk("fill_at_depth", 32'(o_fill), 32'd1024);
    step(1'b1, 32'hDEAD, 1'b0, 1'b1);
    chk("drop_fill", 32'(o_fill), 32'd1024);
    step(1'b1, 32'hBEEF, 1'b1, 1'b1);
    chk("full_rdwr_data", o_data, 32'h1000);
    chk("full_rdwr_fill", 32'(o_fill), 32'd1024);
    chk("full_rdwr_full", 32'(o_full), 32'd1);
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b1);
    chk("drain_last", o_data, 32'hBEEF);
    chk("drain_empty", 32'(o_empty), 32'd1);

    for (int i = 0; i < 500; i++) step(1'b1, $urandom, 1'b0, 1'b1);
    for (int i = 0; i < 3000; i++) step(1'b1, $urandom, 1'b1, 1'b1);
    chk("stream_fill", 32'(o_fill), 32'd500);
    for (int i = 0; i < 500; i++) step(1'b0, '0, 1'b1, 1'b1);

    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 99) < 55, $urandom,
           $urandom_range(0, 99) < 45, 1'b1);

    for (int i = 0; i < 5; i++) step(1'b1, 32'hA0 + i, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);
    #3 i_rst = 1'b1;
    #1;
    chk("rstmid_empty", 32'(o_empty), 32'd1);
    chk("rstmid_full", 32'(o_full), 32'd0);
    chk("rstmid_fill", 32'(o_fill), 32'd0);
    chk("rstmid_data", o_data, 32'd0);
    q.delete();
    m_data = '0;
    #2 i_rst = 1'b0;
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b1, 32'h77, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);
    chk("post_rst_read", o_data, 32'h77);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
